// File: rtl/bit_serial_multiplier_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bit_serial_multiplier_ctrl
// Purpose  : Sequencer for a bit-serial multiplier slice array. Accepts one
//            pair of W-bit unsigned operands per transaction. It streams them
//            LSB-first into slice 0 as x/y/xy and drives the r token and the
//            last_bit pulse. It collects the 2W serial product bits from
//            p_bit into a parallel result, which it offers over valid/ready.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   W         operand width (product is 2W bits)
//   LAT       cycles from driving bit t on x/y to product bit t on p_bit
// Ports
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   in_valid  operand pair a/b valid         in_ready  accepting (IDLE only)
//   a, b      multiplicand / multiplier (unsigned, W bits)
//   x_bit     serial multiplicand bit        y_bit     serial multiplier bit
//   xy_bit    x_bit & y_bit                  r_tok     pulse at bit 0
//   last_bit  pulse at bit 2W-1              p_bit     serial product bit in
//   out_valid p holds a complete product     out_ready consumer accepts p
//   p         parallel product (2W bits)     busy      RUN or DONE
// Configuration
//   BSM_CTRL_SELF_CHECK_EN : adds a sticky 'mismatch' output. It compares p
//   against a*b on entry to DONE, and an r_tok/last_bit exclusivity assertion.
// ============================================================================
module bit_serial_multiplier_ctrl #(
    parameter int W   = 8,
    parameter int LAT = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             x_bit,
    output logic             y_bit,
    output logic             xy_bit,
    output logic             r_tok,
    output logic             last_bit,
    input  logic             p_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   p,
    output logic             busy
`ifdef BSM_CTRL_SELF_CHECK_EN
    ,
    output logic             mismatch
`endif
);

    localparam int c_cnt_w = $clog2(2*W + LAT + 1);

    // Last RUN cycle: the final product bit arrives here.
    localparam logic [c_cnt_w-1:0] c_final   = c_cnt_w'(2*W + LAT - 1);
    // last_bit is registered, so it is loaded one cycle before t = 2W-1.
    localparam logic [c_cnt_w-1:0] c_last_m1 = c_cnt_w'(2*W - 2);
    localparam logic [c_cnt_w-1:0] c_lat     = c_cnt_w'(LAT);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [W-1:0]       r_a_sh;
    logic [W-1:0]       r_b_sh;
    logic               r_x;
    logic               r_y;
    logic               r_xy;
    logic               r_tok_q;
    logic               r_last;
    logic [2*W-1:0]     r_p;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_busy;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (in_valid)           w_state_next = c_st_run;
            c_st_run:  if (r_cnt == c_final)   w_state_next = c_st_done;
            c_st_done: if (out_ready)          w_state_next = c_st_idle;
            default:                           w_state_next = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // State-decoded outputs (from the state register only, never inputs)
    // ------------------------------------------------------------------
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            c_st_idle: w_in_ready  = 1'b1;
            c_st_run:  w_busy      = 1'b1;
            c_st_done: begin
                w_out_valid = 1'b1;
                w_busy      = 1'b1;
            end
            default:   w_in_ready  = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: serial streams, bit counter, product collection.
    // The operand shift registers hold the bits not yet presented, so each
    // registered x/y value is simply the next LSB; they run dry after W
    // shifts, which yields the zero padding for t >= W.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_x     <= 1'b0;
            r_y     <= 1'b0;
            r_xy    <= 1'b0;
            r_tok_q <= 1'b0;
            r_last  <= 1'b0;
            r_p     <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (in_valid) begin
                        r_cnt   <= '0;
                        r_a_sh  <= a >> 1;
                        r_b_sh  <= b >> 1;
                        r_x     <= a[0];
                        r_y     <= b[0];
                        r_xy    <= a[0] & b[0];
                        r_tok_q <= 1'b1;
                        r_last  <= 1'b0;
                        r_p     <= '0;
                    end
                end
                c_st_run: begin
                    r_x     <= r_a_sh[0];
                    r_y     <= r_b_sh[0];
                    r_xy    <= r_a_sh[0] & r_b_sh[0];
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_tok_q <= 1'b0;
                    r_last  <= (r_cnt == c_last_m1);
                    // Product bits arrive LSB first; shifting in at the MSB
                    // lands bit 0 at p[0] after exactly 2W captures.
                    if (r_cnt >= c_lat) begin
                        r_p <= {p_bit, r_p[2*W-1:1]};
                    end
                    if (r_cnt == c_final) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    // DONE: hold p stable until the consumer takes it.
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign busy      = w_busy;
    assign x_bit     = r_x;
    assign y_bit     = r_y;
    assign xy_bit    = r_xy;
    assign r_tok     = r_tok_q;
    assign last_bit  = r_last;
    assign p         = r_p;

`ifdef BSM_CTRL_SELF_CHECK_EN
    // ------------------------------------------------------------------
    // Reference multiplier: compares the completed product on DONE entry.
    // ------------------------------------------------------------------
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic           r_mismatch;
    logic [2*W-1:0] w_p_final;
    logic [2*W-1:0] w_ref;

    // Value r_p takes on the RUN->DONE edge, including the last bit.
    assign w_p_final = {p_bit, r_p[2*W-1:1]};
    assign w_ref     = {{W{1'b0}}, r_a} * {{W{1'b0}}, r_b};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_mismatch <= 1'b0;
        end else begin
            if ((r_state == c_st_idle) && in_valid) begin
                r_a <= a;
                r_b <= b;
            end
            if ((r_state == c_st_run) && (r_cnt == c_final) && (w_p_final != w_ref)) begin
                r_mismatch <= 1'b1;
            end
        end
    end

    assign mismatch = r_mismatch;

    generate
        if (W >= 1) begin : g_tok_last_chk
            a_tok_last_excl: assert property (@(posedge clk) disable iff (!reset_n)
                !(r_tok_q && r_last));
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_bit_serial_multiplier_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_serial_multiplier_ctrl
// Purpose  : Scoreboard testbench for bit_serial_multiplier_ctrl (W=8, LAT=1).
//            A causal array model rebuilds the operands from the x/y streams
//            and returns product bit t one cycle later. A negedge monitor
//            checks stream timing and pops expected products from a queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_serial_multiplier_ctrl;

    localparam int W   = 8;
    localparam int LAT = 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          x_bit;
    logic          y_bit;
    logic          xy_bit;
    logic          r_tok;
    logic          last_bit;
    logic          p_bit = 1'b0;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] p;
    logic          busy;
`ifdef BSM_CTRL_SELF_CHECK_EN
    logic          mismatch;
`endif

    bit_serial_multiplier_ctrl #(.W(W), .LAT(LAT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .x_bit     (x_bit),
        .y_bit     (y_bit),
        .xy_bit    (xy_bit),
        .r_tok     (r_tok),
        .last_bit  (last_bit),
        .p_bit     (p_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
`ifdef BSM_CTRL_SELF_CHECK_EN
        ,
        .mismatch  (mismatch)
`endif
    );

    always #5 clk = ~clk;

    int             compared   = 0;
    int             mismatched = 0;
    logic [15:0]    exp_q[$];
    int             n_pushed   = 0;
    int             n_popped   = 0;
    bit             flip_en    = 1'b0;
    logic [15:0]    exp_xor    = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Ideal array model: product bit t depends only on operand bits 0..t,
    // so it is computed from the bits seen so far and returned LAT=1 later.
    // ------------------------------------------------------------------
    int              mt = -1;
    longint unsigned acc_a, acc_b, prod;
    bit              pend = 1'b0;

    always @(negedge clk) begin
        if (!reset_n) begin
            mt    = -1;
            p_bit = 1'b0;
            pend  = 1'b0;
            acc_a = 0;
            acc_b = 0;
        end else begin
            p_bit = pend;
            pend  = 1'b0;
            if (r_tok) begin
                mt    = 0;
                acc_a = 0;
                acc_b = 0;
            end
            if (mt >= 0) begin
                if (x_bit) acc_a |= (64'd1 << mt);
                if (y_bit) acc_b |= (64'd1 << mt);
                prod = acc_a * acc_b;
                pend = prod[mt];
                if (flip_en && mt == 4) pend = ~pend;
                mt++;
                if (mt == 2*W) mt = -1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: stream timing, latency, DONE behaviour, scoreboard pops.
    // ------------------------------------------------------------------
    int           rt = -1;
    logic [W-1:0] cur_a, cur_b;
    logic [15:0]  held_p;
    bit           hold_seen = 1'b0;
    bit           post_hs   = 1'b0;

    always @(negedge clk) begin
        if (!reset_n) begin
            rt        = -1;
            hold_seen = 1'b0;
            post_hs   = 1'b0;
        end else begin
            if (rt >= 0) begin
                if (rt <= 2*W + LAT - 1) begin
                    chk("r_tok_pos", r_tok, rt == 0);
                    chk("last_bit_pos", last_bit, rt == 2*W - 1);
                    if (rt < W) begin
                        chk("x_bit", x_bit, cur_a[rt]);
                        chk("y_bit", y_bit, cur_b[rt]);
                        chk("xy_bit", xy_bit, cur_a[rt] & cur_b[rt]);
                    end else begin
                        chk("xy_pad_zero", {x_bit, y_bit, xy_bit}, 3'b000);
                    end
                    chk("run_flags", {out_valid, in_ready, busy}, 3'b001);
                    rt++;
                end else begin
                    chk("latency_out_valid", out_valid, 1'b1);
                    rt = -1;
                end
            end
            if (in_valid && in_ready) begin
                rt    = 0;
                cur_a = a;
                cur_b = b;
            end
            if (post_hs) begin
                chk("idle_after_hs", {out_valid, in_ready, busy}, 3'b010);
                post_hs = 1'b0;
            end
            if (out_valid) begin
                chk("done_flags", {in_ready, busy}, 2'b01);
                if (!hold_seen) begin
                    held_p    = p;
                    hold_seen = 1'b1;
                end else begin
                    chk("p_stable", p, held_p);
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", out_valid, 1'b0);
                    end else begin
                        chk("product", p, exp_q.pop_front());
                        n_popped++;
                    end
                    hold_seen = 1'b0;
                    post_hs   = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus tasks (called at posedge+1)
    // ------------------------------------------------------------------
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input bit hold);
        int n;
        a        = ta;
        b        = tb;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        chk("accept_timeout", n >= 200, 1'b0);
        exp_q.push_back((16'(ta) * 16'(tb)) ^ exp_xor);
        n_pushed++;
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", n >= 500, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_outputs", {x_bit, y_bit, xy_bit, r_tok, last_bit, out_valid, busy}, 7'd0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_p", p, 16'h0000);
        n_pushed -= exp_q.size();
        exp_q.delete();
        @(negedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {x_bit, y_bit, xy_bit, r_tok, last_bit, out_valid, busy}, 7'd0);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_p", p, 16'h0000);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed products
        send(8'h0F, 8'h11, 1'b0);
        drain();
        send(8'hFF, 8'hFF, 1'b0);
        send(8'h00, 8'h5A, 1'b0);
        drain();

        // Backpressure: five DONE cycles with out_ready low
        out_ready = 1'b0;
        send(8'hFF, 8'hFF, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 100);
        chk("bp_wait_timeout", n >= 100, 1'b0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Reset in the middle of RUN at t=6
        send(8'hA5, 8'h3C, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        do_reset();
        send(8'd3, 8'd5, 1'b0);
        drain();

        // in_valid held high across transactions
        send(8'd1, 8'd1, 1'b1);
        send(8'd2, 8'd3, 1'b1);
        send(8'h80, 8'h80, 1'b0);
        drain();

        // Randomized transactions
        for (int i = 0; i < 25; i++) begin
            send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        in_valid = 1'b0;
        drain();

`ifdef BSM_CTRL_SELF_CHECK_EN
        do_reset();
        chk("mismatch_reset", mismatch, 1'b0);
        flip_en = 1'b1;
        exp_xor = 16'h0010;
        send(8'h12, 8'h34, 1'b0);
        drain();
        flip_en = 1'b0;
        exp_xor = 16'h0000;
        chk("mismatch_set", mismatch, 1'b1);
        send(8'd5, 8'd7, 1'b0);
        drain();
        chk("mismatch_sticky", mismatch, 1'b1);
        do_reset();
        chk("mismatch_cleared", mismatch, 1'b0);
`endif

        chk("queue_empty", exp_q.size(), 0);
        chk("result_count", n_popped, n_pushed);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
